// File: rtl/miriscv_irq_ctrl.sv
// Interrupt controller for miriscv: edge-captured pending bits, lowest-index
// priority, and a serialised request/ack/return handshake with the trap logic.
module miriscv_irq_ctrl #(
  parameter int unsigned N_IRQ      = 16,
  parameter int unsigned CAUSE_BASE = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_IRQ-1:0] irq_lines_i,
  input  logic [N_IRQ-1:0] irq_en_i,
  input  logic             glob_en_i,
  output logic             irq_o,
  output logic [31:0]      irq_cause_o,
  input  logic             irq_ack_i,
  input  logic             irq_ret_i,
  output logic [N_IRQ-1:0] pending_o
);

  localparam int unsigned IDW = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [N_IRQ-1:0] prev_q;
  logic [N_IRQ-1:0] pending_q, pending_d;
  logic [N_IRQ-1:0] rise;
  logic [N_IRQ-1:0] eligible;
  logic [N_IRQ-1:0] clr;
  logic [IDW-1:0]   winner;
  logic             any_eligible;
  logic             cur_en;
  logic             irq_q;

  assign rise     = irq_lines_i & ~prev_q;
  assign eligible = pending_q & irq_en_i & {N_IRQ{glob_en_i}};

  // Scan from the top down so the lowest eligible index is the last to write.
  always_comb begin
    winner       = '0;
    any_eligible = 1'b0;
    cur_en       = 1'b0;
    for (int k = N_IRQ - 1; k >= 0; k--) begin
      if (eligible[k]) begin
        winner       = IDW'(k);
        any_eligible = 1'b1;
      end
      if (id_q == IDW'(k)) cur_en = irq_en_i[k];
    end
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    clr     = '0;
    case (state_q)
      IDLE: begin
        if (any_eligible) begin
          id_d    = winner;
          state_d = REQ;
        end
      end
      REQ: begin
        if (irq_ack_i) begin
          for (int k = 0; k < N_IRQ; k++) clr[k] = (id_q == IDW'(k));
          state_d = SERVICE;
        end else if (!cur_en || !glob_en_i) begin
          state_d = IDLE;
        end
      end
      SERVICE: begin
        if (irq_ret_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A fresh edge on the line being acknowledged must survive the clear.
  assign pending_d = (pending_q & ~clr) | rise;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      id_q      <= '0;
      prev_q    <= '0;
      pending_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      prev_q    <= irq_lines_i;
      pending_q <= pending_d;
      irq_q     <= (state_d == REQ);
    end
  end

  assign irq_o       = irq_q;
  assign irq_cause_o = {1'b1, 31'(CAUSE_BASE) + 31'(id_q)};
  assign pending_o   = pending_q;

endmodule

// File: doc/miriscv_irq_ctrl.md
# miriscv_irq_ctrl

Interrupt controller for the miriscv core. Captures rising edges on up to 16 external interrupt lines into pending bits, applies per-line and global enables, picks the highest-priority line, and runs a request/acknowledge/return handshake with the core's trap logic. It sits between peripherals and `miriscv_core` inside `miriscv_top`, alongside the RAM. It serialises interrupt service: no nesting.

## Interface

Parameters:
- `N_IRQ`, 16: number of interrupt lines; legal range 1..16.
- `CAUSE_BASE`, 16: exception code reported for line 0; line k reports `CAUSE_BASE + k`.

Ports:
- `clk_i`  in  1  core clock; all state changes on its rising edge.
- `rst_i`  in  1  synchronous reset, active-high.
- `irq_lines_i`  in  N_IRQ  raw interrupt lines from peripherals, synchronous to `clk_i`.
- `irq_en_i`  in  N_IRQ  per-line enable (mie bits from CSR file).
- `glob_en_i`  in  1  global enable (mstatus.MIE).
- `irq_o`  out  1  interrupt request to core.
- `irq_cause_o`  out  32  mcause value for the requested line: bit 31 = 1, bits 30:0 = `CAUSE_BASE + id`.
- `irq_ack_i`  in  1  core has taken the trap for the current request.
- `irq_ret_i`  in  1  core executed `mret`.
- `pending_o`  out  N_IRQ  pending register, for CSR read (mip).

## Operation

- Edge capture: `prev` register samples `irq_lines_i` each cycle. `pending[k]` sets at the edge where `irq_lines_i[k]=1` and `prev[k]=0`. Level held high gives one pending event only.
- Eligible set = `pending & irq_en_i`, gated by `glob_en_i`. Priority: lowest index wins.
- FSM, 3 states:
  - IDLE: `irq_o=0`. If eligible set is non-empty, latch winner id into `id_q` and go to REQ.
  - REQ: `irq_o=1`, `irq_cause_o` from `id_q`.
    - `irq_ack_i=1`: clear `pending[id_q]` and go to SERVICE.
    - Otherwise, if `irq_en_i[id_q]=0` or `glob_en_i=0`: withdraw. Go to IDLE; `pending[id_q]` is kept.
    - `id_q` does not change in REQ, even if a higher-priority line becomes pending. Arbitration happens only in IDLE.
  - SERVICE: `irq_o=0`. New edges still set pending bits. `irq_ret_i=1` returns to IDLE.
- `irq_ret_i` outside SERVICE is ignored. `irq_ack_i` outside REQ is ignored.
- Same-cycle set and clear of the same pending bit (new edge on `id_q` during ack): set wins, so the bit stays 1.
- Bits of `irq_lines_i` / `irq_en_i` at index ≥ `N_IRQ` do not exist. The cause arithmetic is 31-bit unsigned with no overflow for legal parameters.

## Timing

- Reset (`rst_i=1` at an edge) gives: `pending=0`, `prev=0`, state IDLE, `id_q=0`, `irq_o=0`, `irq_cause_o=0x8000_0000 + CAUSE_BASE` (id 0), `pending_o=0`.
- Reset mid-operation, in any state, takes effect the same edge. An outstanding request is dropped with no ack required.
- A line high at reset release counts as an edge (`prev=0`).
- Latency with both enables set and state IDLE:
  - Line rises before edge E1: pending set after E1.
  - State REQ and `irq_o=1` after E2, so 2 cycles from sampled edge to request.
- `irq_o` and `irq_cause_o` are registered outputs. `irq_cause_o` holds `id_q` in every state.
- `irq_ack_i` sampled at edge En: `irq_o=0` after En, and the pending bit is cleared after En.
- After `irq_ret_i` at edge Em, state is IDLE. The next request appears after Em+1 at the earliest.
- Back-to-back service therefore needs ≥1 IDLE cycle.

## Test plan

- Single line: pulse `irq_lines_i[3]` for 1 cycle with all enables set. Required: `irq_o=1` two edges later, `irq_cause_o=0x8000_0013`. Ack gives `pending_o=0` and `irq_o=0`. `irq_ret_i` returns to IDLE.
- Priority: raise lines 5 and 2 in the same cycle. Required: cause `0x8000_0012` first. After ack and ret, request for line 5 with cause `0x8000_0015`.
- Masking and withdraw: line 7 pending, state REQ, drop `irq_en_i[7]` with no ack. Required: `irq_o=0` next edge and `pending_o[7]` still 1. Re-enable gives `irq_o=1` again 1 edge later.
- Level hold: keep line 0 high for 20 cycles and service it once. Required: exactly one request, no second one after `irq_ret_i`.
- Simultaneous events:
  - Line 4 rises again in the ack cycle of line 4. Required: `pending_o[4]` remains 1, and line 4 is requested again after ret.
  - Assert `irq_ret_i` in IDLE. Required: no state change.
- Reset mid-REQ: assert `rst_i` while `irq_o=1`. Required: `irq_o=0` and `pending_o=0` after that edge, and no request afterwards until a new edge occurs.
